// File: rtl/mpc_div_div_28s_6ns_21_seq_if.sv
// Request/response bundle for the sequential 28s/6ns divider: operands, start/ready handshake,
// clock enable and the registered result.
interface mpc_div_div_28s_6ns_21_seq_if #(
  parameter int din0_WIDTH = 28,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 21
);
  logic                  ce;
  logic                  start;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  ready;
  logic                  done;
  logic [dout_WIDTH-1:0] dout;
  logic [din1_WIDTH:0]   rem;
  logic                  ovf;
  logic                  dz;

  modport master (
    output ce, start, din0, din1,
    input  ready, done, dout, rem, ovf, dz
  );

  modport slave (
    input  ce, start, din0, din1,
    output ready, done, dout, rem, ovf, dz
  );
endinterface

// File: rtl/mpc_div_div_28s_6ns_21_seq.sv
// Radix-2 restoring divider, 28b signed / 6b unsigned -> saturated 21b quotient + exact remainder.
// Latency din0_WIDTH+1 enabled cycles (1 for divide-by-zero); start ignored while busy, ce=0 freezes all.
module mpc_div_div_28s_6ns_21_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 28,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 21
) (
  input  logic                         clk,
  input  logic                         reset,
  mpc_div_div_28s_6ns_21_seq_if.slave  bus
);
  localparam int N  = din0_WIDTH;
  localparam int M  = din1_WIDTH;
  localparam int DW = dout_WIDTH;
  localparam int CW = $clog2(N);

  localparam logic [DW-1:0] DOUT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] DOUT_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [N-1:0]  QPOS_LIM = N'((1 << (DW-1)) - 1);
  localparam logic [N-1:0]  QNEG_LIM = N'(1 << (DW-1));

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [N-1:0]    dvd_q,   dvd_d;
  logic [M-1:0]    prem_q,  prem_d;
  logic [M-1:0]    div_q,   div_d;
  logic            neg_q,   neg_d;
  logic            done_q,  done_d;
  logic [DW-1:0]   dout_q,  dout_d;
  logic [M:0]      rem_q,   rem_d;
  logic            ovf_q,   ovf_d;
  logic            dz_q,    dz_d;

  logic [M:0]      shl;
  logic            take;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    prem_d  = prem_q;
    div_d   = div_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    // dvd_q holds remaining dividend bits on top and shifts quotient bits in from below
    shl  = {prem_q, dvd_q[N-1]};
    take = (shl >= {1'b0, div_q});

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          neg_d   = bus.din0[N-1];
          dvd_d   = bus.din0[N-1] ? (~bus.din0 + 1'b1) : bus.din0;
          div_d   = bus.din1;
          prem_d  = '0;
          cnt_d   = CW'(N - 1);
          state_d = (bus.din1 == '0) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        prem_d = take ? (shl[M-1:0] - div_q) : shl[M-1:0];
        dvd_d  = {dvd_q[N-2:0], take};
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (div_q == '0) begin
          dz_d   = 1'b1;
          ovf_d  = 1'b0;
          rem_d  = '0;
          dout_d = neg_q ? DOUT_MIN : DOUT_MAX;
        end else begin
          dz_d  = 1'b0;
          rem_d = neg_q ? -{1'b0, prem_q} : {1'b0, prem_q};
          if (neg_q) begin
            ovf_d  = (dvd_q > QNEG_LIM);
            dout_d = (dvd_q > QNEG_LIM) ? DOUT_MIN : -dvd_q[DW-1:0];
          end else begin
            ovf_d  = (dvd_q > QPOS_LIM);
            dout_d = (dvd_q > QPOS_LIM) ? DOUT_MAX : dvd_q[DW-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      prem_q  <= '0;
      div_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else if (bus.ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      prem_q  <= prem_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.ready = (state_q == S_IDLE);
  assign bus.done  = done_q;
  assign bus.dout  = dout_q;
  assign bus.rem   = rem_q;
  assign bus.ovf   = ovf_q;
  assign bus.dz    = dz_q;
endmodule

// File: tb/tb_mpc_div_div_28s_6ns_21_seq.sv
// Directed bench for the sequential divider: latency, signed results, saturation,
// divide-by-zero, clock-enable freeze, ignored busy starts and mid-operation reset.
module tb_mpc_div_div_28s_6ns_21_seq;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_rise   = 0;
  int   exp_dones = 0;
  logic done_prev = 1'b0;

  mpc_div_div_28s_6ns_21_seq_if #(.din0_WIDTH(28), .din1_WIDTH(6), .dout_WIDTH(21)) bus ();

  mpc_div_div_28s_6ns_21_seq #(.ID(1), .din0_WIDTH(28), .din1_WIDTH(6), .dout_WIDTH(21)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done === 1'b1 && done_prev !== 1'b1) n_rise++;
    done_prev = bus.done;
  end

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One division; fz_at/fz_len drop ce for fz_len edges after edge fz_at,
  // poke_at pulses a second start while busy, stretch holds ce low once done rises.
  task automatic run(input string tag, input longint a, input longint b,
                     input longint eq, input longint er, input logic eovf, input logic edz,
                     input int elat, input int fz_at, input int fz_len, input int poke_at,
                     input bit stretch);
    int lat;
    bit got;
    @(negedge clk);
    chk({tag, "_ready"}, bus.ready, 1);
    bus.start = 1'b1;
    bus.din0  = 28'(a);
    bus.din1  = 6'(b);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    got = 0;
    while (!got && lat < 100) begin
      bus.ce    = !(fz_len > 0 && lat >= fz_at && lat < fz_at + fz_len);
      bus.start = (poke_at > 0 && lat == poke_at);
      if (bus.start) begin
        bus.din0 = 28'd1;
        bus.din1 = 6'd1;
      end
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) got = 1;
    end
    bus.ce    = 1'b1;
    bus.start = 1'b0;
    exp_dones++;
    chk({tag, "_lat"},  lat, elat);
    chk({tag, "_q"},    $signed(bus.dout), eq);
    chk({tag, "_rem"},  $signed(bus.rem), er);
    chk({tag, "_ovf"},  bus.ovf, eovf);
    chk({tag, "_dz"},   bus.dz, edz);
    if (stretch) begin
      bus.ce = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_stretch"}, bus.done, 1);
      bus.ce = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, bus.done, 0);
    chk({tag, "_hold"},  $signed(bus.dout), eq);
  endtask

  initial begin
    bus.ce    = 1'b1;
    bus.start = 1'b0;
    bus.din0  = '0;
    bus.din1  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.ready, 1);
    chk("rst_done",  bus.done, 0);
    chk("rst_dout",  bus.dout, 0);
    chk("rst_rem",   bus.rem, 0);
    chk("rst_ovf",   bus.ovf, 0);
    chk("rst_dz",    bus.dz, 0);
    reset = 1'b1;

    //    tag        dividend    div  quot      rem ovf   dz    lat fz fl pk st
    run("p1000_7",   1000,       7,   142,      6,  1'b0, 1'b0, 29, 0, 0, 0, 0);
    run("n1000_7",  -1000,       7,  -142,     -6,  1'b0, 1'b0, 29, 0, 0, 0, 0);
    run("n14_7",    -14,         7,  -2,        0,  1'b0, 1'b0, 29, 0, 0, 0, 0);
    run("zero_5",    0,          5,   0,        0,  1'b0, 1'b0, 29, 0, 0, 0, 0);
    run("minint_1", -134217728,  1,  -1048576,  0,  1'b1, 1'b0, 29, 0, 0, 0, 0);
    run("maxint_63", 134217727,  63,  1048575,  7,  1'b1, 1'b0, 29, 0, 0, 0, 0);
    run("negedge",  -66060288,   63, -1048576,  0,  1'b0, 1'b0, 29, 0, 0, 0, 0);
    run("posedge",   66060288,   63,  1048575,  0,  1'b1, 1'b0, 29, 0, 0, 0, 0);
    run("posmax",    66060225,   63,  1048575,  0,  1'b0, 1'b0, 29, 0, 0, 0, 0);
    run("p5_0",      5,          0,   1048575,  0,  1'b0, 1'b1, 1,  0, 0, 0, 0);
    run("n5_0",     -5,          0,  -1048576,  0,  1'b0, 1'b1, 1,  0, 0, 0, 1);
    run("freeze",    1000,       7,   142,      6,  1'b0, 1'b0, 34, 10, 5, 6, 0);

    // A start pulsed while busy must not spawn a second result.
    repeat (40) @(posedge clk);
    #1;
    chk("poke_dones", n_rise, exp_dones);

    // Abort a division with reset at edge 10.
    @(negedge clk);
    bus.start = 1'b1;
    bus.din0  = 28'd1000;
    bus.din1  = 6'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("abort_ready", bus.ready, 1);
    chk("abort_done",  bus.done, 0);
    chk("abort_dout",  bus.dout, 0);
    chk("abort_rem",   bus.rem, 0);
    chk("abort_ovf",   bus.ovf, 0);
    chk("abort_dz",    bus.dz, 0);
    run("p63_8",     63,         8,   7,        7,  1'b0, 1'b0, 29, 0, 0, 0, 0);
    repeat (35) @(posedge clk);
    #1;
    chk("total_dones", n_rise, exp_dones);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
